// File: rtl/vec_max_argmax.sv
`default_nettype none
// ============================================================================
// Module   : vec_max_argmax
// Purpose  : Streaming IEEE float vector reduction returning the maximum value
//            and the index of its first occurrence, with NaN/overflow flags.
// Revision : 1.0
// ============================================================================
module vec_max_argmax #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    IDX_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [BITS-1:0]     a,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     max,
    output logic [IDX_BITS-1:0] max_index,
    output logic                nan_seen,
    output logic                overflow
);

    localparam int EXP_W = (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MAN_W = BITS - 1 - EXP_W;
    localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [BITS-1:0]       max_q, max_d;
    logic [IDX_BITS-1:0]   max_index_q, max_index_d;
    logic                  nan_seen_q, nan_seen_d;
    logic                  overflow_q, overflow_d;
    logic [IDX_BITS-1:0]   cnt_q, cnt_d;
    logic                  have_num_q, have_num_d;

    logic                  w_accept;
    logic                  w_a_nan;

    // Magnitude field only: exponent all ones with a nonzero mantissa.
    function automatic logic is_nan(input logic [BITS-2:0] mag);
        return (&mag[BITS-2 -: EXP_W]) && (|mag[MAN_W-1:0]);
    endfunction

    // Strict IEEE ordering for non-NaN operands; +0 and -0 compare equal.
    function automatic logic greater(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
        logic [BITS-2:0] mx;
        logic [BITS-2:0] my;
        mx = x[BITS-2:0];
        my = y[BITS-2:0];
        if ((mx == '0) && (my == '0))
            return 1'b0;
        if (x[BITS-1] != y[BITS-1])
            return ~x[BITS-1];
        if (!x[BITS-1])
            return mx > my;
        return mx < my;
    endfunction

    assign w_accept = in_valid && in_ready_q;
    assign w_a_nan  = is_nan(a[BITS-2:0]);

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        max_index_d = max_index_q;
        nan_seen_d  = nan_seen_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        have_num_d  = have_num_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    max_d       = w_a_nan ? QNAN : a;
                    have_num_d  = ~w_a_nan;
                    max_index_d = '0;
                    nan_seen_d  = w_a_nan;
                    overflow_d  = 1'b0;
                    cnt_d       = IDX_BITS'(1);
                    state_d     = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    cnt_d = cnt_q + IDX_BITS'(1);
                    // A zero count here means the counter already wrapped.
                    if (cnt_q == '0)
                        overflow_d = 1'b1;
                    if (w_a_nan) begin
                        nan_seen_d = 1'b1;
                    end else if (!have_num_q || greater(a, max_q)) begin
                        max_d       = a;
                        max_index_d = cnt_q;
                        have_num_d  = 1'b1;
                    end
                    if (in_last)
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            max_index_q <= '0;
            nan_seen_q  <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            have_num_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            max_q       <= max_d;
            max_index_q <= max_index_d;
            nan_seen_q  <= nan_seen_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
            have_num_q  <= have_num_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign max       = max_q;
    assign max_index = max_index_q;
    assign nan_seen  = nan_seen_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_max_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_max_argmax
// Purpose  : Self-checking bench: HALF, SINGLE and narrow-index instances.
// Revision : 1.0
// ============================================================================
module tb_vec_max_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] a16;
    logic [31:0] a32;

    logic        in_ready_h, out_valid_h, nan_h, ovf_h;
    logic [15:0] max_h;
    logic [7:0]  idx_h;
    logic        in_ready_s, out_valid_s, nan_s, ovf_s;
    logic [31:0] max_s;
    logic [7:0]  idx_s;
    logic        in_ready_o, out_valid_o, nan_o, ovf_o;
    logic [15:0] max_o;
    logic [1:0]  idx_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vec_max_argmax #(.BITS(16), .PRECISION("HALF"), .IDX_BITS(8)) u_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a16),
        .in_ready(in_ready_h), .out_valid(out_valid_h), .out_ready(out_ready),
        .max(max_h), .max_index(idx_h), .nan_seen(nan_h), .overflow(ovf_h));

    vec_max_argmax #(.BITS(32), .PRECISION("SINGLE"), .IDX_BITS(8)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a32),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .max(max_s), .max_index(idx_s), .nan_seen(nan_s), .overflow(ovf_s));

    vec_max_argmax #(.BITS(16), .PRECISION("HALF"), .IDX_BITS(2)) u_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a16),
        .in_ready(in_ready_o), .out_valid(out_valid_o), .out_ready(out_ready),
        .max(max_o), .max_index(idx_o), .nan_seen(nan_o), .overflow(ovf_o));

    typedef struct {
        int          n;
        logic [15:0] v [4];
        logic [15:0] exp_max;
        int          exp_idx;
        logic        exp_nan;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: real-valued ordering ----------------
    function automatic bit ref_is_nan(input logic [31:0] b, input int ew, input int mw);
        int e;
        int m;
        e = int'((b >> mw) & ((32'd1 << ew) - 1));
        m = int'(b & ((32'd1 << mw) - 1));
        return (e == (1 << ew) - 1) && (m != 0);
    endfunction

    function automatic real to_real(input logic [31:0] b, input int ew, input int mw);
        int  e;
        int  m;
        int  bias;
        real mag;
        bias = (1 << (ew - 1)) - 1;
        e = int'((b >> mw) & ((32'd1 << ew) - 1));
        m = int'(b & ((32'd1 << mw) - 1));
        if (e == (1 << ew) - 1)
            mag = 1.0e308;
        else if (e == 0)
            mag = real'(m) * (2.0 ** (1 - bias - mw));
        else
            mag = (real'(1 << mw) + real'(m)) * (2.0 ** (e - bias - mw));
        return b[ew + mw] ? -mag : mag;
    endfunction

    task automatic model(input logic [31:0] q[$], input int ew, input int mw, input int ib,
                         output logic [31:0] m, output int idx, output bit nan, output bit ovf);
        bit  have;
        real best;
        have = 0;
        best = 0.0;
        m    = (((32'd1 << ew) - 1) << mw) | (32'd1 << (mw - 1));
        idx  = 0;
        nan  = 0;
        foreach (q[i]) begin
            if (ref_is_nan(q[i], ew, mw)) begin
                nan = 1;
            end else if (!have || to_real(q[i], ew, mw) > best) begin
                have = 1;
                best = to_real(q[i], ew, mw);
                m    = q[i];
                idx  = i % (1 << ib);
            end
        end
        ovf = q.size() > (1 << ib);
    endtask

    // ---------------- protocol helpers ----------------
    task automatic send(input logic [31:0] q16[$], input logic [31:0] q32[$], input bit bubbles);
        for (int i = 0; i < q16.size(); i++) begin
            if (bubbles && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                a16      = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a16      = q16[i][15:0];
            a32      = q32[i];
            in_last  = (i == q16.size() - 1);
            chk("in_ready_accept", {31'b0, in_ready_h}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("out_valid_latency", {31'b0, out_valid_h}, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {31'b0, out_valid_h}, 32'd0);
        chk("in_ready_back", {31'b0, in_ready_h}, 32'd1);
    endtask

    function automatic logic [31:0] rand_val(input int ew, input int mw);
        logic [31:0] sgn;
        logic [31:0] inf;
        sgn = 32'($urandom_range(0, 1)) << (ew + mw);
        inf = ((32'd1 << ew) - 1) << mw;
        case ($urandom_range(0, 7))
            0:       return sgn | inf | (32'($urandom) & ((32'd1 << mw) - 1)) | 32'd1;
            1:       return sgn | inf;
            2:       return sgn;
            default: return 32'($urandom) & ((32'd1 << (ew + mw + 1)) - 1);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [5];
        logic [31:0] q16[$];
        logic [31:0] q32[$];
        logic [31:0] em;
        int          ei;
        bit          en;
        bit          eo;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        a16 = '0; a32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready_h}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid_h}, 32'd0);
        chk("rst_max", {16'b0, max_h}, 32'd0);
        chk("rst_flags", {29'b0, nan_h, ovf_o, ovf_h}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{3, '{16'h3C00, 16'h4000, 16'h3800, 16'h0}, 16'h4000, 1, 1'b0};
        tbl[1] = '{3, '{16'h8000, 16'h0000, 16'hC000, 16'h0}, 16'h8000, 0, 1'b0};
        tbl[2] = '{2, '{16'h4200, 16'h4200, 16'h0, 16'h0},    16'h4200, 0, 1'b0};
        tbl[3] = '{4, '{16'h7E01, 16'hBC00, 16'h7C00, 16'h7E00}, 16'h7C00, 2, 1'b1};
        tbl[4] = '{2, '{16'h7E01, 16'h7D00, 16'h0, 16'h0},    16'h7E00, 0, 1'b1};

        for (int k = 0; k < 5; k++) begin
            q16 = {}; q32 = {};
            for (int i = 0; i < tbl[k].n; i++) begin
                q16.push_back({16'b0, tbl[k].v[i]});
                q32.push_back(32'h0);
            end
            send(q16, q32, 1'b0);
            chk("tbl_max", {16'b0, max_h}, {16'b0, tbl[k].exp_max});
            chk("tbl_idx", {24'b0, idx_h}, 32'(tbl[k].exp_idx));
            chk("tbl_nan", {31'b0, nan_h}, {31'b0, tbl[k].exp_nan});
            chk("tbl_ovf_narrow", {31'b0, ovf_o}, 32'd0);
            release_result();
        end

        // SINGLE vector, then hold the result under backpressure
        q16 = '{32'h0, 32'h0};
        q32 = '{32'hC0000000, 32'hBF800000};
        send(q16, q32, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("sgl_hold_max", max_s, 32'hBF800000);
            chk("sgl_hold_idx", {24'b0, idx_s}, 32'd1);
            chk("sgl_hold_valid", {31'b0, out_valid_s}, 32'd1);
            chk("sgl_hold_ready", {31'b0, in_ready_s}, 32'd0);
        end

        // in_valid coincident with out_ready in HOLD is not accepted
        in_valid = 1'b1; in_last = 1'b1; a16 = 16'h4400; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("simul_no_accept", {31'b0, out_valid_h}, 32'd0);
        chk("simul_ready", {31'b0, in_ready_h}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("simul_next_valid", {31'b0, out_valid_h}, 32'd1);
        chk("simul_next_max", {16'b0, max_h}, 32'h4400);
        chk("simul_next_idx", {24'b0, idx_h}, 32'd0);
        release_result();

        // exactly 2^IDX_BITS elements: no overflow on the narrow instance
        q16 = '{32'h3C00, 32'h4000, 32'h3800, 32'h4400};
        q32 = '{32'h0, 32'h0, 32'h0, 32'h0};
        send(q16, q32, 1'b0);
        chk("ovf4_narrow", {31'b0, ovf_o}, 32'd0);
        chk("ovf4_idx", {30'b0, idx_o}, 32'd3);
        release_result();

        // five elements overflow the 2-bit counter, max still correct
        q16 = '{32'h3C00, 32'h4000, 32'h3800, 32'h4400, 32'h3C00};
        q32 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send(q16, q32, 1'b0);
        chk("ovf5_narrow", {31'b0, ovf_o}, 32'd1);
        chk("ovf5_max", {16'b0, max_o}, 32'h4400);
        chk("ovf5_wide", {31'b0, ovf_h}, 32'd0);

        // reset during HOLD clears pending result without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("rsthold_valid", {31'b0, out_valid_h}, 32'd0);
        chk("rsthold_max", {16'b0, max_o}, 32'd0);
        chk("rsthold_ovf", {31'b0, ovf_o}, 32'd0);
        chk("rsthold_ready", {31'b0, in_ready_h}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset mid-vector discards the partial result
        in_valid = 1'b1; in_last = 1'b0; a16 = 16'h7E01;
        @(posedge clk); #1;
        a16 = 16'h4800;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_max", {16'b0, max_h}, 32'd0);
        chk("rstmid_nan", {31'b0, nan_h}, 32'd0);
        chk("rstmid_idx", {24'b0, idx_h}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // randomized vectors against the real-valued model
        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(1, 10);
            q16 = {}; q32 = {};
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 5) == 0) begin
                    q16.push_back(q16[$urandom_range(0, i - 1)]);
                    q32.push_back(q32[$urandom_range(0, i - 1)]);
                end else begin
                    q16.push_back(rand_val(5, 10));
                    q32.push_back(rand_val(8, 23));
                end
            end
            send(q16, q32, 1'b1);
            model(q16, 5, 10, 8, em, ei, en, eo);
            chk("rnd_h_max", {16'b0, max_h}, em);
            chk("rnd_h_idx", {24'b0, idx_h}, 32'(ei));
            chk("rnd_h_nan", {31'b0, nan_h}, {31'b0, en});
            chk("rnd_h_ovf", {31'b0, ovf_h}, {31'b0, eo});
            model(q16, 5, 10, 2, em, ei, en, eo);
            chk("rnd_o_max", {16'b0, max_o}, em);
            chk("rnd_o_ovf", {31'b0, ovf_o}, {31'b0, eo});
            if (!eo)
                chk("rnd_o_idx", {30'b0, idx_o}, 32'(ei));
            model(q32, 8, 23, 8, em, ei, en, eo);
            chk("rnd_s_max", max_s, em);
            chk("rnd_s_idx", {24'b0, idx_s}, 32'(ei));
            chk("rnd_s_nan", {31'b0, nan_s}, {31'b0, en});
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            release_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_max_argmax.md
Name: vec_max_argmax

Overview:
- Streaming reduction block. Accepts a vector of IEEE floating-point values one element per beat and returns the largest value and the zero-based position of its first occurrence.
- Counterpart to the element-wise min path: it produces a vector maximum/argmax for normalisation and peak-search stages in the Precision library.
- Compare logic is internal and selected by PRECISION, so the block needs no external comparator.

Parameters:
- BITS, 16: element width; must be 16 for "HALF" and 32 for "SINGLE".
- PRECISION, "HALF": "HALF" selects exponent [14:10] and mantissa [9:0]; "SINGLE" selects exponent [30:23] and mantissa [22:0].
- IDX_BITS, 8: width of the element index counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: element present on a.
- in_last, input, 1: marks the final element of the vector; qualified by in_valid.
- a, input, BITS: element value.
- in_ready, output, 1: block can accept an element.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- max, output, BITS: maximum value.
- max_index, output, IDX_BITS: index of the first occurrence of max.
- nan_seen, output, 1: at least one NaN was present in the vector.
- overflow, output, 1: the vector contained more than 2^IDX_BITS elements.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; max=0; max_index=0; nan_seen=0; overflow=0; element counter=0.
  - Reset asserted mid-vector or during HOLD discards all partial or pending results.
- Accept rule: a beat is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. On accept, load a as the running max and index 0. Clear nan_seen and overflow, then set them from this beat. Counter=1. Go to HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1. On accept, compare a against the running max. If a is strictly greater, replace the running max and set index=counter. Counter increments. Go to HOLD on in_last.
  - HOLD: in_ready=0; out_valid=1. Outputs are stable until out_ready is sampled high, then go to IDLE with out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, so it is visible in the following cycle. The maximum throughput is one vector of N elements per N+1 cycles.
- No accept in HOLD: in_valid together with out_ready in the same cycle is not accepted. The new vector starts the next cycle, in IDLE.
- Compare rules ("greater"):
  - NaN is exponent all ones with mantissa nonzero. A NaN never becomes the max and sets nan_seen.
  - +0 and -0 are equal, so neither replaces the other.
  - If the signs differ, the positive operand is greater.
  - If both are positive, the larger magnitude (bits [BITS-2:0]) is greater.
  - If both are negative, the smaller magnitude is greater.
  - +Inf and -Inf compare as ordinary extremes.
  - Ties keep the earlier index.
- All-NaN vector: max = canonical quiet NaN (16'h7E00 for HALF, 32'h7FC00000 for SINGLE); max_index=0; nan_seen=1.
- A leading NaN is replaced by the first non-NaN element. That element's index is recorded, even if it is not strictly greater under any rule.
- Counter wrap:
  - When the counter passes 2^IDX_BITS-1, it wraps and overflow is set sticky for the vector.
  - max_index is then undefined beyond the wrap, but max remains correct.
- Single-element vector (in_last on the first beat): result = that element, index 0.
- in_last is ignored when in_valid=0.

Test Plan:
1. HALF: stream 3C00, 4000, 3800 (last) -> out_valid the cycle after the last beat; max=4000, max_index=1, nan_seen=0.
2. HALF ties and zeros: stream 8000, 0000, C000 (last) -> max=8000, max_index=0. A repeated max 4200, 4200 gives index 0.
3. HALF NaN: stream 7E01, BC00, 7C00, 7E00 (last) -> max=7C00, max_index=2, nan_seen=1. An all-NaN vector of 7E01, 7D00 -> max=7E00, index 0, nan_seen=1.
4. SINGLE (BITS=32): stream C0000000, BF800000 (last) -> max=BF800000, max_index=1. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
5. Backpressure and simultaneity: assert in_valid in HOLD in the same cycle as out_ready -> beat not accepted. It is accepted the next cycle, and out_valid drops.
6. Reset and overflow: assert rst mid-vector -> all outputs return to reset values immediately. With IDX_BITS=2, stream 5 elements -> overflow=1 and max still correct.
